// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - round-robin arbiter turning two requesters' accesses into RAM command word pairs
module spi_ram_arbiter #(
  parameter int MEM_WIDTH  = 8,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [MEM_WIDTH-1:0] addr0,
  input  logic [MEM_WIDTH-1:0] wdata0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [MEM_WIDTH-1:0] addr1,
  input  logic [MEM_WIDTH-1:0] wdata1,
  output logic                 ack1,
  output logic [MEM_WIDTH-1:0] rdata,
  output logic                 err,
  output logic                 busy,
  output logic [MEM_WIDTH+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic                 ram_tx_valid,
  input  logic [MEM_WIDTH-1:0] ram_dout
);
  localparam int CW = $clog2(RD_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RD_WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic [MEM_WIDTH-1:0]   addr_q, addr_d;
  logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MEM_WIDTH+1:0]   din_d;
  logic [MEM_WIDTH-1:0]   rdata_d;
  logic                   rx_valid_d, ack0_d, ack1_d, err_d, finish, pick0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    din_d        = ram_din;
    rdata_d      = rdata;
    rx_valid_d   = 1'b0;
    err_d        = 1'b0;
    finish       = 1'b0;
    // On contention requester 0 wins only if requester 1 was served last
    pick0        = req0 && (!req1 || last_grant_q);
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d      = !pick0;
          last_grant_d = !pick0;
          we_d         = pick0 ? we0 : we1;
          addr_d       = pick0 ? addr0 : addr1;
          wdata_d      = pick0 ? wdata0 : wdata1;
          din_d        = {we_d ? 2'b00 : 2'b10, addr_d};
          rx_valid_d   = 1'b1;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        din_d      = we_q ? {2'b01, wdata_q} : {2'b11, {MEM_WIDTH{1'b0}}};
        rx_valid_d = 1'b1;
        state_d    = DATA;
      end
      DATA: begin
        if (we_q) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ram_tx_valid) begin
          rdata_d = ram_dout;
          finish  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack0_d = finish && !grant_q;
    ack1_d = finish && grant_q;
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      ram_din      <= din_d;
      ram_rx_valid <= rx_valid_d;
      rdata        <= rdata_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
      err          <= err_d;
      busy         <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - self-checking bench for spi_ram_arbiter with a command-decoding RAM model
module tb_spi_ram_arbiter;
  localparam int MW = 8;
  localparam int RT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [MW-1:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic ack0, ack1, err, busy, ram_rx_valid, ram_tx_valid;
  logic [MW-1:0] rdata, ram_dout;
  logic [MW+1:0] ram_din;

  spi_ram_arbiter #(.MEM_WIDTH(MW), .RD_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err), .busy(busy),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // RAM device model: decodes command words, answers a read rsp_delay cycles into RD_WAIT (<0: never)
  logic [7:0] ram_mem [256];
  bit         ram_init = 0;
  logic [7:0] ram_a = '0;
  bit         armed = 0;
  int         cnt = 0;
  logic       mv = 1'b0;
  logic [7:0] mdout = '0;
  logic       stray = 1'b0;
  int         rsp_delay = 0;
  logic [9:0] words [$];

  assign ram_tx_valid = mv | stray;
  assign ram_dout     = mv ? mdout : 8'hFF;

  always @(negedge clk) begin
    if (!ram_init) begin
      foreach (ram_mem[i]) ram_mem[i] = '0;
      ram_init = 1;
    end
    mv = 1'b0;
    if (armed) begin
      if (cnt == 0) begin
        mv    = 1'b1;
        mdout = ram_mem[ram_a];
        armed = 0;
      end else cnt--;
    end
    if (ram_rx_valid) begin
      words.push_back(ram_din);
      case (ram_din[9:8])
        2'b00, 2'b10: ram_a = ram_din[7:0];
        2'b01:        ram_mem[ram_a] = ram_din[7:0];
        default: if (rsp_delay >= 0) begin armed = 1; cnt = rsp_delay; end
      endcase
    end
  end

  // Transaction-level reference model
  bit         ref_last = 1;
  logic [7:0] ref_rd = '0;
  logic [7:0] ref_mem [256];

  task automatic predict(input bit r0, input bit r1, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                         input bit w1, input logic [7:0] a1, input logic [7:0] d1, input int dly,
                         output int win, output int lat, output bit e, output logic [7:0] rd,
                         output logic [9:0] wa, output logic [9:0] wb);
    bit we, to;
    logic [7:0] a, d;
    win = (r0 && r1) ? (ref_last ? 0 : 1) : (r1 ? 1 : 0);
    ref_last = (win == 1);
    we = win ? w1 : w0;
    a  = win ? a1 : a0;
    d  = win ? d1 : d0;
    to = !we && (dly < 0 || dly >= RT);
    lat = we ? 3 : (to ? 3 + RT : 4 + dly);
    if (we) ref_mem[a] = d;
    else if (!to) ref_rd = ref_mem[a];
    e  = to;
    rd = ref_rd;
    wa = {we ? 2'b00 : 2'b10, a};
    wb = we ? {2'b01, d} : 10'h300;
  endtask

  task automatic run_txn(input bit r0, input bit r1, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                         input bit w1, input logic [7:0] a1, input logic [7:0] d1, input int dly, input bit hold,
                         input int ewin, input int elat, input bit eerr, input logic [7:0] erd,
                         input logic [9:0] ewa, input logic [9:0] ewb);
    int lat;
    int base;
    bit got;
    lat = 0;
    got = 0;
    @(negedge clk);
    base = words.size();
    rsp_delay = dly;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        chk("busy_start", busy, 1);
        chk("rx_valid_addr", ram_rx_valid, 1);
      end
      if (ack0 || ack1) got = 1;
    end
    chk("ack_seen", got, 1);
    chk("latency", lat, elat);
    chk("ack_winner", {ack1, ack0}, ewin ? 2 : 1);
    chk("err", err, eerr);
    chk("rdata", rdata, erd);
    chk("ram_word_count", words.size() - base, 2);
    if (words.size() - base >= 2) begin
      chk("ram_word_addr", words[base], ewa);
      chk("ram_word_data", words[base+1], ewb);
    end
    if (!hold) begin req0 = 0; req1 = 0; end
    @(posedge clk); #1;
    chk("ack_one_cycle", {ack1, ack0, err}, 0);
    chk("busy_idle", busy, 0);
  endtask

  typedef struct {
    bit         sel;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         dly;
    int         lat;
    bit         err;
    logic [7:0] rd;
    logic [9:0] wa;
    logic [9:0] wb;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int pw, pl;
    bit pe;
    logic [7:0] prd;
    logic [9:0] pwa, pwb;
    bit s, w;
    logic [7:0] a, d;
    int r, dl;

    foreach (ref_mem[i]) ref_mem[i] = '0;
    tbl[0] = '{0, 1, 8'h3C, 8'hA5,  0,  3, 0, 8'h00, 10'h03C, 10'h1A5};
    tbl[1] = '{1, 0, 8'h3C, 8'h00,  0,  4, 0, 8'hA5, 10'h23C, 10'h300};
    tbl[2] = '{0, 0, 8'h3C, 8'h00,  5,  9, 0, 8'hA5, 10'h23C, 10'h300};
    tbl[3] = '{1, 1, 8'h10, 8'h5A,  0,  3, 0, 8'hA5, 10'h010, 10'h15A};
    tbl[4] = '{0, 0, 8'h10, 8'h00,  0,  4, 0, 8'h5A, 10'h210, 10'h300};
    tbl[5] = '{1, 0, 8'h3C, 8'h00, -1, 19, 1, 8'h5A, 10'h23C, 10'h300};
    tbl[6] = '{0, 0, 8'h3C, 8'h00, 15, 19, 0, 8'hA5, 10'h23C, 10'h300};
    tbl[7] = '{1, 1, 8'hFF, 8'h00,  0,  3, 0, 8'hA5, 10'h0FF, 10'h100};
    tbl[8] = '{0, 0, 8'hFF, 8'h00,  1,  5, 0, 8'h00, 10'h2FF, 10'h300};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", ram_rx_valid, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      predict(!tbl[i].sel, tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata,
              tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dly, pw, pl, pe, prd, pwa, pwb);
      run_txn(!tbl[i].sel, tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata,
              tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].dly, 0,
              tbl[i].sel, tbl[i].lat, tbl[i].err, tbl[i].rd, tbl[i].wa, tbl[i].wb);
    end

    // Stray RAM responses in IDLE and during a write must be ignored
    @(negedge clk) stray = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray_idle_rdata", rdata, ref_rd);
      chk("stray_idle_ack", {ack1, ack0}, 0);
    end
    predict(1, 0, 1, 8'h20, 8'h33, 1, 8'h20, 8'h33, 0, pw, pl, pe, prd, pwa, pwb);
    run_txn(1, 0, 1, 8'h20, 8'h33, 1, 8'h20, 8'h33, 0, 0, pw, pl, pe, prd, pwa, pwb);
    @(negedge clk) stray = 1'b0;

    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      r  = int'($urandom_range(0, 9));
      dl = (r < 6) ? r : (r == 6) ? 15 : (r == 7) ? -1 : 2;
      predict(!s, s, w, a, d, w, a, d, dl, pw, pl, pe, prd, pwa, pwb);
      run_txn(!s, s, w, a, d, w, a, d, dl, 0, pw, pl, pe, prd, pwa, pwb);
    end

    // Reset in the middle of RD_WAIT
    @(negedge clk);
    rsp_delay = -1;
    req0 = 1; we0 = 0; addr0 = 8'h05;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ack0", ack0, 0);
    chk("mid_rst_ack1", ack1, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_valid", ram_rx_valid, 0);
    chk("mid_rst_ram_din", ram_din, 0);
    chk("mid_rst_rdata", rdata, 0);
    req0 = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_ack", {ack0, ack1, busy}, 0);
    end
    @(negedge clk) rst = 1'b0;
    ref_last = 1;
    ref_rd   = '0;

    // Both requesters held continuously right after reset: grants 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      predict(1, 1, 1, 8'h40, 8'(8'h11 + k), 0, 8'h40, 8'h00, 0, pw, pl, pe, prd, pwa, pwb);
      run_txn(1, 1, 1, 8'h40, 8'(8'h11 + k), 0, 8'h40, 8'h00, 0, (k != 3),
              k % 2, pl, pe, prd, pwa, pwb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
